rsa256_uart_bridge: RTL and testbench

//  Avalon-MM master between the RS232 UART IP and the RSA-256 decrypt core.

---
 rtl/rsa256_uart_bridge_pkg.sv | 12 +
 rtl/rsa256_uart_bridge.sv | 120 ++++++++++++
 tb/tb_rsa256_uart_bridge.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa256_uart_bridge_pkg.sv
// rsa_pkg: UART register map, status bits and FSM enums for the RSA-256 UART bridge
package rsa_pkg;
  localparam logic [4:0] RX_BASE = 5'd0;
  localparam logic [4:0] TX_BASE = 5'd1;
  localparam logic [4:0] STATUS_BASE = 5'd2;
  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;
  localparam int IN_BYTES = 32;
  localparam int OUT_BYTES = 31;
  typedef enum logic [2:0] {S_QUERY_RX, S_READ, S_CALC, S_QUERY_TX, S_WRITE} state_t;
  typedef enum logic [1:0] {GET_N, GET_D, GET_A} phase_t;
endpackage

// File: rtl/rsa256_uart_bridge.sv
// rsa256_uart_bridge: Avalon-MM master feeding UART bytes to the RSA-256 core and returning plaintext
module rsa256_uart_bridge
  import rsa_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_a_pow_d,
  input  logic         i_core_finished
);
  state_t state, state_n;
  phase_t phase, phase_n;
  logic [4:0] byte_cnt, cnt_n, addr_n;
  logic [255:0] res, res_n, n_n, d_n, a_n;
  logic [31:0] wd_n;
  logic rd_n, wr_n, start_n, done, rx_last, tx_last;
  assign done = (avm_read | avm_write) & ~avm_waitrequest;
  assign rx_last = byte_cnt == 5'(IN_BYTES - 1);
  assign tx_last = byte_cnt == 5'(OUT_BYTES - 1);
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n = byte_cnt;
    n_n = o_core_n;
    d_n = o_core_d;
    a_n = o_core_a;
    res_n = res;
    addr_n = avm_address;
    rd_n = avm_read;
    wr_n = avm_write;
    wd_n = avm_writedata;
    start_n = 1'b0;
    unique case (state)
      S_QUERY_RX:
        if (!avm_read) begin
          rd_n = 1'b1;
          addr_n = STATUS_BASE;
        end else if (done && avm_readdata[RX_OK_BIT]) begin
          state_n = S_READ;
          addr_n = RX_BASE;
        end
      S_READ:
        if (done) begin
          n_n = phase == GET_N ? {o_core_n[247:0], avm_readdata[7:0]} : o_core_n;
          d_n = phase == GET_D ? {o_core_d[247:0], avm_readdata[7:0]} : o_core_d;
          a_n = phase == GET_A ? {o_core_a[247:0], avm_readdata[7:0]} : o_core_a;
          cnt_n = rx_last ? 5'd0 : byte_cnt + 5'd1;
          phase_n = !rx_last ? phase : phase == GET_N ? GET_D : GET_A;
          state_n = rx_last && phase == GET_A ? S_CALC : S_QUERY_RX;
          rd_n = !(rx_last && phase == GET_A);
          start_n = rx_last && phase == GET_A;
          addr_n = STATUS_BASE;
        end
      // a finished coinciding with the start pulse cannot belong to this block
      S_CALC:
        if (i_core_finished && !o_core_start) begin
          res_n = i_core_a_pow_d;
          state_n = S_QUERY_TX;
          rd_n = 1'b1;
          addr_n = STATUS_BASE;
        end
      S_QUERY_TX:
        if (done && avm_readdata[TX_OK_BIT]) begin
          state_n = S_WRITE;
          rd_n = 1'b0;
          wr_n = 1'b1;
          addr_n = TX_BASE;
          wd_n = {24'd0, res[247:240]};
        end
      S_WRITE:
        if (done) begin
          res_n = {res[247:0], 8'd0};
          cnt_n = tx_last ? 5'd0 : byte_cnt + 5'd1;
          phase_n = tx_last ? GET_A : phase;
          state_n = tx_last ? S_QUERY_RX : S_QUERY_TX;
          wr_n = 1'b0;
          rd_n = 1'b1;
          addr_n = STATUS_BASE;
        end
      default: ;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= S_QUERY_RX;
      phase <= GET_N;
      byte_cnt <= '0;
      res <= '0;
      o_core_n <= '0;
      o_core_d <= '0;
      o_core_a <= '0;
      avm_address <= '0;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      avm_writedata <= '0;
      o_core_start <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      byte_cnt <= cnt_n;
      res <= res_n;
      o_core_n <= n_n;
      o_core_d <= d_n;
      o_core_a <= a_n;
      avm_address <= addr_n;
      avm_read <= rd_n;
      avm_write <= wr_n;
      avm_writedata <= wd_n;
      o_core_start <= start_n;
    end
endmodule

// File: tb/tb_rsa256_uart_bridge.sv
// tb_rsa256_uart_bridge: UART slave and RSA core models driving the bridge, with byte-stream scoreboarding
module tb_rsa256_uart_bridge;
  logic clk = 0, rst = 0;
  logic [4:0] avm_address;
  logic avm_read, avm_write, avm_waitrequest = 0, o_core_start, i_core_finished = 0;
  logic [31:0] avm_readdata = 0, avm_writedata;
  logic [255:0] o_core_a, o_core_d, o_core_n, i_core_a_pow_d = 0;
  int checks = 0, errors = 0;
  logic [7:0] rxq[$], exp_tx[$], txlog[$], stream2[$];
  logic [255:0] exp_a[$], exp_n, exp_d, snap_a, snap_d, snap_n;
  bit stall_en, poll_en, spur_en, fixed_res;
  int tx_count, starts;
  localparam logic [255:0] RES_FIXED = 256'h00AABBCCDDEEFF0102030405060708090A0B0C0D0E0F10111213141516171819;
  localparam logic [255:0] KEY_N = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_D = 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;

  rsa256_uart_bridge dut (
    .i_clk(clk), .i_rst(rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
    .i_core_a_pow_d(i_core_a_pow_d), .i_core_finished(i_core_finished)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // UART slave: random stalls, status polling gates, rx byte source, tx byte sink
  bit busy, rx_granted, tx_granted, rok, tok;
  int stall, rx_wait, tx_wait;
  logic [38:0] cap;
  logic [31:0] rv;
  logic [7:0] b;
  always @(negedge clk) begin
    if (rst) begin
      busy = 0; avm_waitrequest = 0; rx_granted = 0; tx_granted = 0; rx_wait = 0; tx_wait = 0;
    end else begin
      rv = $urandom;
      if (avm_read || avm_write) chk("one_of_rw", avm_read && avm_write, 0);
      if (busy) chk("stable_while_stalled", {avm_address, avm_read, avm_write, avm_writedata}, cap);
      else if (avm_read || avm_write) begin
        busy = 1;
        cap = {avm_address, avm_read, avm_write, avm_writedata};
        stall = stall_en ? int'($urandom_range(0, 5)) : 0;
      end
      avm_readdata = rv;
      avm_waitrequest = 0;
      if (busy && stall > 0) begin
        avm_waitrequest = 1;
        stall--;
      end else if (busy) begin
        busy = 0;
        if (cap[33] && cap[38:34] == 5'd2) begin
          rok = rxq.size() > 0 && (!poll_en || rx_wait >= 10);
          tok = exp_tx.size() > 0 && (!poll_en || tx_wait >= 10);
          if (rxq.size() > 0 && !rok) rx_wait++;
          if (exp_tx.size() > 0 && !tok) tx_wait++;
          rx_granted = rok;
          tx_granted = tok;
          avm_readdata = {rv[31:8], rok, tok, rv[5:0]};
        end else if (cap[33] && cap[38:34] == 5'd0) begin
          chk("rx_read_gated", rx_granted, 1);
          chk("rx_byte_available", rxq.size() > 0, 1);
          b = rxq.size() > 0 ? rxq.pop_front() : rv[7:0];
          rx_granted = 0;
          rx_wait = 0;
          avm_readdata = {rv[31:8], b};
        end else if (cap[32] && cap[38:34] == 5'd1) begin
          chk("tx_write_gated", tx_granted, 1);
          chk("tx_upper_zero", cap[31:8], 0);
          chk("tx_expected", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) chk("tx_byte", cap[7:0], exp_tx.pop_front());
          tx_granted = 0;
          tx_wait = 0;
          txlog.push_back(cap[7:0]);
          tx_count++;
        end else chk("access_address", cap, 0);
      end
    end
  end

  // RSA core stub: checks operands at start, returns a result after a random latency
  bit calc_pending, prev_start;
  int delay;
  logic [255:0] res;
  always @(negedge clk) begin
    if (rst) begin
      calc_pending = 0; i_core_finished = 0; prev_start = 0;
    end else begin
      i_core_finished = 0;
      if (!calc_pending && spur_en && $urandom_range(0, 6) == 0) begin
        i_core_finished = 1;
        i_core_a_pow_d = rnd256();
      end
      if (o_core_start) begin
        chk("start_single_cycle", prev_start, 0);
        chk("start_expected", exp_a.size() > 0, 1);
        chk("start_n", o_core_n, exp_n);
        chk("start_d", o_core_d, exp_d);
        if (exp_a.size() > 0) chk("start_a", o_core_a, exp_a.pop_front());
        snap_a = o_core_a; snap_d = o_core_d; snap_n = o_core_n;
        calc_pending = 1;
        delay = $urandom_range(2, 12);
        starts++;
      end else if (calc_pending) begin
        chk("ops_stable_in_calc", {o_core_a ^ snap_a} | {o_core_d ^ snap_d} | {o_core_n ^ snap_n}, 0);
        if (delay == 0) begin
          res = fixed_res ? RES_FIXED : rnd256();
          i_core_finished = 1;
          i_core_a_pow_d = res;
          for (int i = 30; i >= 0; i--) exp_tx.push_back(res[i*8 +: 8]);
          calc_pending = 0;
        end else delay--;
      end
      prev_start = o_core_start;
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_avm"}, {avm_address, avm_read, avm_write, avm_writedata, o_core_start}, 0);
    chk({nm, "_n"}, o_core_n, 0);
    chk({nm, "_d"}, o_core_d, 0);
    chk({nm, "_a"}, o_core_a, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    rxq.delete(); exp_tx.delete(); exp_a.delete(); txlog.delete();
    tx_count = 0; starts = 0;
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("first_status_read", {avm_read, avm_write, avm_address}, {1'b1, 1'b0, 5'd2});
  endtask

  task automatic push_op(input logic [255:0] k);
    for (int i = 31; i >= 0; i--) rxq.push_back(k[i*8 +: 8]);
  endtask

  task automatic load_keys(input logic [255:0] n, input logic [255:0] d);
    exp_n = n; exp_d = d;
    push_op(n); push_op(d);
  endtask

  task automatic push_block(input logic [255:0] a);
    exp_a.push_back(a);
    push_op(a);
  endtask

  task automatic wait_tx(input int n, input string nm);
    int c = 0;
    while ((tx_count < n || rxq.size() > 0) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_tx_count"}, tx_count, n);
    repeat (3) @(negedge clk);
  endtask

  logic [255:0] a1;
  int c, mism;
  initial begin
    stall_en = 0; poll_en = 0; spur_en = 0; fixed_res = 1;
    #1 do_reset();
    load_keys(KEY_N, KEY_D);
    c = 0;
    while (rxq.size() > 0 && c < 5000) begin @(negedge clk); c++; end
    chk("keys_consumed", rxq.size(), 0);
    repeat (3) @(negedge clk);
    chk("key_n_literal", o_core_n, KEY_N);
    chk("key_d_literal", o_core_d, KEY_D);
    chk("no_start_after_keys", starts, 0);
    a1 = rnd256();
    push_block(a1);
    wait_tx(31, "block");
    chk("block_starts", starts, 1);
    chk("tx0_literal", txlog[0], 8'hAA);
    chk("tx1_literal", txlog[1], 8'hBB);
    chk("tx30_literal", txlog[30], 8'h19);
    stream2 = txlog;

    stall_en = 1;
    do_reset();
    load_keys(KEY_N, KEY_D);
    push_block(a1);
    wait_tx(31, "stall");
    mism = 0;
    foreach (stream2[i]) if (txlog.size() <= i || txlog[i] !== stream2[i]) mism++;
    chk("stall_stream_same", mism, 0);

    stall_en = 0; poll_en = 1; fixed_res = 0;
    do_reset();
    load_keys(rnd256(), rnd256());
    push_block(rnd256());
    wait_tx(31, "poll");
    chk("poll_starts", starts, 1);

    poll_en = 0; stall_en = 1; spur_en = 1;
    do_reset();
    load_keys(rnd256(), rnd256());
    for (int i = 0; i < 3; i++) push_block(rnd256());
    wait_tx(93, "multi");
    chk("multi_starts", starts, 3);
    chk("multi_keys_n", o_core_n, exp_n);
    chk("multi_keys_d", o_core_d, exp_d);

    stall_en = 0; spur_en = 0;
    do_reset();
    load_keys(rnd256(), rnd256());
    push_block(rnd256());
    c = 0;
    while (!calc_pending && c < 5000) begin @(negedge clk); c++; end
    chk("reached_calc", calc_pending, 1);
    #2 rst = 1;
    #1 check_zero("rst_in_calc");
    do_reset();
    load_keys(rnd256(), rnd256());
    push_block(rnd256());
    c = 0;
    while (!avm_write && c < 5000) begin @(negedge clk); c++; end
    chk("reached_write", avm_write, 1);
    #2 rst = 1;
    #1 check_zero("rst_in_write");
    do_reset();
    load_keys(rnd256(), rnd256());
    push_block(rnd256());
    wait_tx(31, "reload");
    chk("reload_n", o_core_n, exp_n);
    chk("reload_d", o_core_d, exp_d);
    chk("reload_starts", starts, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
